// File: rtl/scan_chain_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : scan_chain_ctrl
//  Purpose  : Drives the CSOC scan chain. SCAN shifts host bytes into the
//             chain (LSB first) while capturing the bits that come out, and
//             RUN issues a counted burst of functional CSOC clocks.
//             Optional build macro SCAN_ASCII_EN: every captured chain bit is
//             returned as its own ASCII '0'/'1' byte instead of packed bytes.
//  Revision : 1.0  initial release
// ============================================================================
module scan_chain_ctrl #(
    parameter int CHAIN_LEN = 1919,
    parameter int CLK_DIV   = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [1:0] cmd_op_i,
    input  logic [15:0] nclks_i,
    input  logic       din_valid_i,
    input  logic [7:0] din_i,
    output logic       din_ready_o,
    output logic       dout_valid_o,
    output logic [7:0] dout_o,
    input  logic       dout_ready_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       csoc_clk_o,
    output logic       csoc_test_se_o,
    output logic       csoc_test_tm_o,
    output logic [7:0] csoc_data_o,
    input  logic [7:0] csoc_data_i
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD     = 3'd1;
    localparam logic [2:0] S_SHIFT_LO = 3'd2;
    localparam logic [2:0] S_SHIFT_HI = 3'd3;
    localparam logic [2:0] S_EMIT     = 3'd4;
    localparam logic [2:0] S_RUN_LO   = 3'd5;
    localparam logic [2:0] S_RUN_HI   = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    localparam logic [1:0]  OP_SCAN    = 2'b00;
    localparam logic [1:0]  OP_RUN     = 2'b01;
    localparam logic [11:0] CHAIN_BITS = 12'(CHAIN_LEN);
    localparam logic [11:0] LAST_BIT   = 12'(CHAIN_LEN - 1);
    localparam logic [7:0]  DIV_LAST   = 8'(CLK_DIV - 1);

    logic [2:0]  state;
    logic [2:0]  state_next;
    logic [7:0]  div_cnt;      // cycles spent in the current clock phase
    logic [11:0] bit_cnt;      // chain bits fully shifted so far
    logic [15:0] run_cnt;      // RUN rising edges still to issue
    logic [7:0]  din_byte;
    logic [7:0]  dout_byte;

    logic        accept;
    logic        phase_end;
    logic        timed_state;
    logic        emit_now;
    logic        unused_data_bits;

    // Only bit 7 of the chain return bus carries scan data
    assign unused_data_bits = ^csoc_data_i[6:0];

    assign accept      = (state == S_IDLE) && cmd_valid_i;
    assign phase_end   = (div_cnt == DIV_LAST);
    assign timed_state = (state == S_SHIFT_LO) || (state == S_SHIFT_HI) ||
                         (state == S_RUN_LO)   || (state == S_RUN_HI);

`ifdef SCAN_ASCII_EN
    assign emit_now = 1'b1;
`else
    // A packed byte is complete after its 8th bit or the final chain bit
    assign emit_now = (bit_cnt[2:0] == 3'd7) || (bit_cnt == LAST_BIT);
`endif

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; handshake stalls simply hold LOAD/EMIT with the clock low
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    if (cmd_op_i == OP_SCAN) begin
                        state_next = S_LOAD;
                    end else if (cmd_op_i == OP_RUN) begin
                        state_next = (nclks_i == 16'd0) ? S_DONE : S_RUN_LO;
                    end
                end
            end
            S_LOAD: begin
                if (din_valid_i) begin
                    state_next = S_SHIFT_LO;
                end
            end
            S_SHIFT_LO: begin
                if (phase_end) begin
                    state_next = S_SHIFT_HI;
                end
            end
            S_SHIFT_HI: begin
                if (phase_end) begin
                    state_next = emit_now ? S_EMIT : S_SHIFT_LO;
                end
            end
            S_EMIT: begin
                // bit_cnt already counts the bit just finished
                if (dout_ready_i) begin
                    if (bit_cnt == CHAIN_BITS) begin
                        state_next = S_DONE;
                    end else if (bit_cnt[2:0] == 3'd0) begin
                        state_next = S_LOAD;
                    end else begin
                        state_next = S_SHIFT_LO;
                    end
                end
            end
            S_RUN_LO: begin
                if (phase_end) begin
                    state_next = S_RUN_HI;
                end
            end
            S_RUN_HI: begin
                if (phase_end) begin
                    state_next = (run_cnt == 16'd1) ? S_DONE : S_RUN_LO;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Phase timer, bit/edge counters and the in/out byte buffers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_cnt   <= 8'd0;
            bit_cnt   <= 12'd0;
            run_cnt   <= 16'd0;
            din_byte  <= 8'd0;
            dout_byte <= 8'd0;
        end else begin
            if (timed_state && (state_next == state)) begin
                div_cnt <= div_cnt + 8'd1;
            end else begin
                div_cnt <= 8'd0;
            end

            if (accept && (cmd_op_i == OP_SCAN)) begin
                bit_cnt <= 12'd0;
            end else if ((state == S_SHIFT_HI) && phase_end) begin
                bit_cnt <= bit_cnt + 12'd1;
            end

            if (accept && (cmd_op_i == OP_RUN)) begin
                run_cnt <= nclks_i;
            end else if ((state == S_RUN_HI) && phase_end) begin
                run_cnt <= run_cnt - 16'd1;
            end

            if ((state == S_LOAD) && din_valid_i) begin
                din_byte <= din_i;
`ifndef SCAN_ASCII_EN
                // Clearing here leaves unused bits of a final partial byte at 0
                dout_byte <= 8'd0;
`endif
            end

            // Capture the chain output just before the rising CSOC edge
            if ((state == S_SHIFT_LO) && phase_end) begin
`ifdef SCAN_ASCII_EN
                dout_byte <= {7'b0011000, csoc_data_i[7]};
`else
                dout_byte[bit_cnt[2:0]] <= csoc_data_i[7];
`endif
            end
        end
    end

    // Output decode, purely from the current state
    always_comb begin
        cmd_ready_o    = (state == S_IDLE);
        din_ready_o    = (state == S_LOAD);
        dout_valid_o   = (state == S_EMIT);
        dout_o         = dout_byte;
        busy_o         = (state != S_IDLE);
        done_o         = (state == S_DONE);
        csoc_clk_o     = (state == S_SHIFT_HI) || (state == S_RUN_HI);
        csoc_test_se_o = (state == S_LOAD) || (state == S_SHIFT_LO) ||
                         (state == S_SHIFT_HI) || (state == S_EMIT);
        csoc_test_tm_o = (state != S_IDLE);
        csoc_data_o    = 8'd0;
        if ((state == S_SHIFT_LO) || (state == S_SHIFT_HI)) begin
            csoc_data_o[0] = din_byte[bit_cnt[2:0]];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_scan_chain_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_scan_chain_ctrl
//  Purpose  : Self-checking bench for scan_chain_ctrl. Instance A
//             (CHAIN_LEN=10, CLK_DIV=1) is looped through a 10-flop chain
//             model for SCAN traffic; instance B (CHAIN_LEN=10, CLK_DIV=2)
//             exercises RUN. Honors SCAN_ASCII_EN for expected scan-out.
//  Revision : 1.0  initial release
// ============================================================================
module tb_scan_chain_ctrl;

    localparam int CL    = 10;
    localparam int DIV_B = 2;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic        cmd_valid_a = 1'b0, cmd_valid_b = 1'b0;
    logic [1:0]  cmd_op = 2'b00;
    logic [15:0] nclks = 16'd0;
    logic        din_valid = 1'b0;
    logic [7:0]  din = 8'd0;
    logic        dout_ready = 1'b1;

    logic cmd_ready_a, din_ready_a, dout_valid_a, busy_a, done_a, cclk_a, se_a, tm_a;
    logic cmd_ready_b, din_ready_b, dout_valid_b, busy_b, done_b, cclk_b, se_b, tm_b;
    logic [7:0] dout_a, dout_b, cdo_a, cdo_b, cdi_a;
    logic [7:0] cdi_b = 8'd0;

    scan_chain_ctrl #(.CHAIN_LEN(CL), .CLK_DIV(1)) u_dut_a (
        .clk(clk), .rstn(rstn),
        .cmd_valid_i(cmd_valid_a), .cmd_ready_o(cmd_ready_a), .cmd_op_i(cmd_op), .nclks_i(nclks),
        .din_valid_i(din_valid), .din_i(din), .din_ready_o(din_ready_a),
        .dout_valid_o(dout_valid_a), .dout_o(dout_a), .dout_ready_i(dout_ready),
        .busy_o(busy_a), .done_o(done_a),
        .csoc_clk_o(cclk_a), .csoc_test_se_o(se_a), .csoc_test_tm_o(tm_a),
        .csoc_data_o(cdo_a), .csoc_data_i(cdi_a)
    );

    scan_chain_ctrl #(.CHAIN_LEN(CL), .CLK_DIV(DIV_B)) u_dut_b (
        .clk(clk), .rstn(rstn),
        .cmd_valid_i(cmd_valid_b), .cmd_ready_o(cmd_ready_b), .cmd_op_i(cmd_op), .nclks_i(nclks),
        .din_valid_i(din_valid), .din_i(din), .din_ready_o(din_ready_b),
        .dout_valid_o(dout_valid_b), .dout_o(dout_b), .dout_ready_i(dout_ready),
        .busy_o(busy_b), .done_o(done_b),
        .csoc_clk_o(cclk_b), .csoc_test_se_o(se_b), .csoc_test_tm_o(tm_b),
        .csoc_data_o(cdo_b), .csoc_data_i(cdi_b)
    );

    // 10-flop CSOC chain model: shifts toward bit 9, bit 9 drives scan-out
    logic [CL-1:0] chain = '1;
    always @(posedge cclk_a) chain <= {chain[CL-2:0], cdo_a[0]};
    assign cdi_a = {chain[CL-1], 7'b0};

    int edges_a = 0, edges_b = 0, done_cnt_a = 0, done_cnt_b = 0;
    always @(posedge cclk_a) edges_a <= edges_a + 1;
    always @(posedge cclk_b) edges_b <= edges_b + 1;
    always @(posedge done_a) done_cnt_a <= done_cnt_a + 1;
    always @(posedge done_b) done_cnt_b <= done_cnt_b + 1;

    int checks = 0;
    int errors = 0;
    logic [7:0]    exp_q[$];
    logic [CL-1:0] golden = '1;   // expected chain contents, bench-side

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_scan(input logic [7:0] b0, input logic [7:0] b1,
                           input int dout_stall, input int din_stall);
        logic [7:0]    bytes[2];
        logic [7:0]    acc;
        logic [7:0]    held;
        logic [CL-1:0] ngold;
        int idx, cyc, e0, d0, es, pops, stall_left, din_gap;
        bit fin;
        bytes[0] = b0;
        bytes[1] = b1;
        acc = 8'd0;
        held = 8'd0;
        for (int i = 0; i < CL; i++) begin
`ifdef SCAN_ASCII_EN
            exp_q.push_back({7'b0011000, golden[CL-1-i]});
`else
            acc[i % 8] = golden[CL-1-i];
            if ((i % 8 == 7) || (i == CL-1)) begin
                exp_q.push_back(acc);
                acc = 8'd0;
            end
`endif
            ngold[CL-1-i] = bytes[i / 8][i % 8];
        end
        e0 = edges_a;
        d0 = done_cnt_a;
        es = 0;
        check("scan_cmd_ready", cmd_ready_a, 1'b1);
        cmd_op = 2'b00;
        cmd_valid_a = 1'b1;
        @(negedge clk);
        cmd_valid_a = 1'b0;
        check("scan_busy", busy_a, 1'b1);
        check("scan_tm", tm_a, 1'b1);
        idx = 0; cyc = 0; pops = 0; fin = 0;
        stall_left = dout_stall;
        din_gap = din_stall;
        while (cyc < 2000 && !fin) begin
            if (done_a) begin
                fin = 1;
            end else begin
                if (din_ready_a && din_gap > 0) begin
                    din_valid = 1'b0;
                    din_gap--;
                end else begin
                    din_valid = (idx < 2);
                    if (idx < 2) din = bytes[idx];
                    if (din_valid && din_ready_a) idx++;
                end
                if (dout_valid_a) begin
                    if (pops == 1 && stall_left > 0) begin
                        if (stall_left == dout_stall) begin
                            held = dout_a;
                            es = edges_a;
                        end else begin
                            check("stall_dout_stable", dout_a, held);
                        end
                        dout_ready = 1'b0;
                        stall_left--;
                        if (stall_left == 0) check("stall_no_csoc_edge", edges_a, es);
                    end else begin
                        dout_ready = 1'b1;
                        if (exp_q.size() == 0) check("scan_sb_underflow", 1, 0);
                        else check("scan_dout", dout_a, exp_q.pop_front());
                        pops++;
                    end
                end else begin
                    dout_ready = 1'b1;
                end
                @(negedge clk);
                cyc++;
            end
        end
        din_valid = 1'b0;
        dout_ready = 1'b1;
        check("scan_done_seen", fin, 1'b1);
        check("scan_sb_empty", exp_q.size(), 0);
        check("scan_csoc_edges", edges_a - e0, CL);
        check("scan_chain_loaded", chain, ngold);
        golden = ngold;
        exp_q.delete();
        @(negedge clk);
        check("scan_done_pulses", done_cnt_a - d0, 1);
        check("scan_done_width", done_a, 1'b0);
        check("scan_idle_after", busy_a, 1'b0);
    endtask

    // Accept happens in the cycle where valid&ready are high; cycle c counts
    // cycles after it, so done is expected in c = 2*DIV*n + 1 (c = 1 for n = 0)
    task automatic do_run(input logic [15:0] n, input bit poke_busy);
        int e0, d0, c, done_c, hi_run;
        bit fin, se_bad;
        e0 = edges_b;
        d0 = done_cnt_b;
        check("run_cmd_ready", cmd_ready_b, 1'b1);
        cmd_op = 2'b01;
        nclks = n;
        cmd_valid_b = 1'b1;
        @(negedge clk);
        cmd_valid_b = 1'b0;
        c = 1; hi_run = 0; fin = 0; se_bad = 0; done_c = 0;
        while (c <= 200 && !fin) begin
            if (done_b) begin
                fin = 1;
                done_c = c;
            end else begin
                if (se_b) se_bad = 1;
                if (cclk_b) begin
                    hi_run++;
                end else if (hi_run > 0) begin
                    check("run_high_cycles", hi_run, DIV_B);
                    hi_run = 0;
                end
                if (poke_busy && c == 3) begin
                    cmd_op = 2'b00;
                    nclks = 16'd3;
                    cmd_valid_b = 1'b1;
                end else begin
                    cmd_valid_b = 1'b0;
                end
                @(negedge clk);
                c++;
            end
        end
        cmd_valid_b = 1'b0;
        if (hi_run > 0) check("run_high_cycles", hi_run, DIV_B);
        check("run_done_seen", fin, 1'b1);
        check("run_done_cycle", done_c, (n == 0) ? 1 : 2 * DIV_B * int'(n) + 1);
        check("run_edges", edges_b - e0, int'(n));
        check("run_se_low", se_bad, 1'b0);
        repeat (3) @(negedge clk);
        check("run_done_pulses", done_cnt_b - d0, 1);
        check("run_idle_after", busy_b, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy_a, 1'b0);
        check({tag, "_done"}, done_a, 1'b0);
        check({tag, "_din_ready"}, din_ready_a, 1'b0);
        check({tag, "_dout_valid"}, dout_valid_a, 1'b0);
        check({tag, "_dout"}, dout_a, 8'h00);
        check({tag, "_csoc"}, {cclk_a, se_a, tm_a, cdo_a}, 11'd0);
    endtask

    initial begin
        int e0, d0, cyc;
        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rstn = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready_a, 1'b1);

        // Chain preloaded all ones: returns 0xFF,0x03 (packed)
        do_scan(8'hA5, 8'h03, 0, 0);
        // Reads back the A5/03 pattern, with a 50-cycle dout stall and a din stall
        do_scan(8'h3C, 8'h02, 50, 5);
        do_scan(8'h00, 8'h01, 0, 2);

        // Reserved opcode is consumed without starting anything
        e0 = edges_b;
        d0 = done_cnt_b;
        cmd_op = 2'b10;
        cmd_valid_b = 1'b1;
        @(negedge clk);
        cmd_valid_b = 1'b0;
        check("badop_busy", busy_b, 1'b0);
        repeat (2) @(negedge clk);
        check("badop_no_done", done_cnt_b - d0, 0);
        check("badop_no_edge", edges_b - e0, 0);

        do_run(16'd5, 1'b1);
        do_run(16'd0, 1'b0);
        do_run(16'd1, 1'b0);

        // Reset in the middle of a scan, while bit 4 is shifting
        e0 = edges_a;
        d0 = done_cnt_a;
        din = 8'h5A;
        din_valid = 1'b1;
        cmd_op = 2'b00;
        cmd_valid_a = 1'b1;
        @(negedge clk);
        cmd_valid_a = 1'b0;
        cyc = 0;
        while (edges_a - e0 < 4 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("midrst_reached_bit4", edges_a - e0, 4);
        check("midrst_busy_before", busy_a, 1'b1);
        rstn = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        din_valid = 1'b0;
        rstn = 1'b1;
        e0 = edges_a;
        @(negedge clk);
        check("midrst_cmd_ready", cmd_ready_a, 1'b1);
        repeat (20) @(negedge clk);
        check("midrst_no_done", done_cnt_a - d0, 0);
        check("midrst_no_edge", edges_a - e0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
